// File: rtl/serial_add_core.sv
// Bit-serial ripple adder: captures two WIDTH-bit operands plus carry-in and streams the
// sum out LSB first, one bit per cycle, then reports the final carry-out with a done pulse.
module serial_add_core #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic                       cin,
   output logic                       s,
   output logic                       c,
   output logic                       s_valid,
   output logic [$clog2(WIDTH):0]     bit_idx,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StAdd, StFin} state_e;

   state_e           r_state, w_state;
   logic [WIDTH-1:0] r_a, w_a;
   logic [WIDTH-1:0] r_b, w_b;
   logic             r_carry, w_carry;
   logic [CW-1:0]    r_cnt, w_cnt;
   logic [CW-1:0]    r_bit_idx, w_bit_idx;
   logic             r_s, w_s;
   logic             r_s_valid, w_s_valid;
   logic             r_done, w_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_carry   <= 1'b0;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_s       <= 1'b0;
         r_s_valid <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_a       <= w_a;
         r_b       <= w_b;
         r_carry   <= w_carry;
         r_cnt     <= w_cnt;
         r_bit_idx <= w_bit_idx;
         r_s       <= w_s;
         r_s_valid <= w_s_valid;
         r_done    <= w_done;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_a       = r_a;
      w_b       = r_b;
      w_carry   = r_carry;
      w_cnt     = r_cnt;
      w_bit_idx = r_bit_idx;
      w_s       = 1'b0;
      w_s_valid = 1'b0;
      w_done    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_a     = a;
               w_b     = b;
               w_carry = cin;
               w_cnt   = '0;
               w_state = StAdd;
            end
         end
         StAdd: begin
            // Extra ADD cycle with r_cnt == WIDTH lets the last bit be shown before FIN.
            if (r_cnt == CW'(WIDTH)) begin
               w_done  = 1'b1;
               w_state = StFin;
            end else begin
               w_s       = r_a[0] ^ r_b[0] ^ r_carry;
               w_carry   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
               w_a       = r_a >> 1;
               w_b       = r_b >> 1;
               w_bit_idx = r_cnt;
               w_s_valid = 1'b1;
               w_cnt     = r_cnt + CW'(1);
            end
         end
         StFin: begin
            w_state = StIdle;
         end
         default: begin
            w_state = StIdle;
         end
      endcase
   end

   assign s       = r_s;
   assign c       = r_carry;
   assign s_valid = r_s_valid;
   assign bit_idx = r_bit_idx;
   assign done    = r_done;
   assign busy    = (r_state != StIdle);

endmodule

// File: tb/tb_serial_add_core.sv
// Directed bench for serial_add_core: fixed vectors, ignored starts, reset abort and a full
// operand sweep against a+b+cin.
module tb_serial_add_core;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       s;
   logic       c;
   logic       s_valid;
   logic [2:0] bit_idx;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   serial_add_core #(.WIDTH(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .s       (s),
      .c       (c),
      .s_valid (s_valid),
      .bit_idx (bit_idx),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one operation and collects what the DUT emitted; comparisons are made by callers.
   task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic icin,
                         input bit poke, output logic [3:0] bits, output logic oc,
                         output int nvalid, output int ndone, output bit idx_ok,
                         output bit busy_ok, output bit timeout);
      int  nexp;
      bit  got_done;
      bits = 4'b0; oc = 1'b0; nvalid = 0; ndone = 0;
      idx_ok = 1'b1; busy_ok = 1'b0; timeout = 1'b1;
      nexp = 0; got_done = 1'b0;
      a = ia; b = ib; cin = icin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (poke && !got_done) begin
            start = 1'b1; a = ~ia; b = ~ib; cin = ~icin;
         end
         @(posedge clk); #1;
         if (s_valid) begin
            bits[bit_idx[1:0]] = s;
            if (bit_idx != 3'(nexp)) idx_ok = 1'b0;
            nexp++;
            nvalid++;
         end
         if (got_done) begin
            busy_ok = (busy == 1'b0) && (done == 1'b0);
            timeout = 1'b0;
            break;
         end
         if (done) begin
            ndone++;
            oc = c;
            got_done = 1'b1;
            start = 1'b0;
         end
      end
      // One more idle cycle confirms no queued operation started.
      @(posedge clk); #1;
      if (busy || done) busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; a = 4'hF; b = 4'hF; cin = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (s !== 1'b0) begin errors++; $display("FAIL reset_s got %b want 0", s); end
      checks++; if (c !== 1'b0) begin errors++; $display("FAIL reset_c got %b want 0", c); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got %b want 0", s_valid); end
      checks++; if (bit_idx !== 3'd0) begin errors++; $display("FAIL reset_bit_idx got %0d want 0", bit_idx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b want 0", busy); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL release_s_valid got %b want 0", s_valid); end
   endtask

   task automatic test_vectors();
      logic [3:0] va [3]; logic [3:0] vb [3]; logic vcin [3];
      logic [3:0] ebits [3]; logic ec [3];
      logic [3:0] bits; logic oc; int nv; int nd; bit iok; bit bok; bit to;
      va[0] = 4'b0101; vb[0] = 4'b0011; vcin[0] = 1'b0; ebits[0] = 4'b1000; ec[0] = 1'b0;
      va[1] = 4'b1111; vb[1] = 4'b0001; vcin[1] = 1'b0; ebits[1] = 4'b0000; ec[1] = 1'b1;
      va[2] = 4'b1111; vb[2] = 4'b1111; vcin[2] = 1'b1; ebits[2] = 4'b1111; ec[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], vcin[i], 1'b0, bits, oc, nv, nd, iok, bok, to);
         checks++; if (to) begin errors++; $display("FAIL vec%0d_timeout no done seen", i); end
         checks++; if (bits !== ebits[i]) begin errors++; $display("FAIL vec%0d_bits got %b want %b", i, bits, ebits[i]); end
         checks++; if (oc !== ec[i]) begin errors++; $display("FAIL vec%0d_carry got %b want %b", i, oc, ec[i]); end
         checks++; if (nv != 4) begin errors++; $display("FAIL vec%0d_valid_cycles got %0d want 4", i, nv); end
         checks++; if (nd != 1) begin errors++; $display("FAIL vec%0d_done_count got %0d want 1", i, nd); end
         checks++; if (!iok) begin errors++; $display("FAIL vec%0d_bit_idx order got bad want 0..3", i); end
      end
   endtask

   task automatic test_ignore_start();
      logic [3:0] bits; logic oc; int nv; int nd; bit iok; bit bok; bit to;
      run_op(4'b0101, 4'b0011, 1'b0, 1'b1, bits, oc, nv, nd, iok, bok, to);
      checks++; if (to) begin errors++; $display("FAIL ignore_timeout no done seen"); end
      checks++; if (bits !== 4'b1000) begin errors++; $display("FAIL ignore_bits got %b want 1000", bits); end
      checks++; if (oc !== 1'b0) begin errors++; $display("FAIL ignore_carry got %b want 0", oc); end
      checks++; if (nd != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", nd); end
      checks++; if (!bok) begin errors++; $display("FAIL ignore_busy_after_fin got busy want idle"); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] bits; logic oc; int nv; int nd; bit iok; bit bok; bit to;
      run_op(4'b0110, 4'b0111, 1'b1, 1'b0, bits, oc, nv, nd, iok, bok, to);
      checks++; if ({oc, bits} !== 5'd14) begin errors++; $display("FAIL b2b_first got %0d want 14", {oc, bits}); end
      run_op(4'b1001, 4'b1000, 1'b0, 1'b0, bits, oc, nv, nd, iok, bok, to);
      checks++; if ({oc, bits} !== 5'd17) begin errors++; $display("FAIL b2b_second got %0d want 17", {oc, bits}); end
   endtask

   task automatic test_reset_abort();
      logic [3:0] bits; logic oc; int nv; int nd; bit iok; bit bok; bit to;
      bit seen;
      seen = 1'b0;
      a = 4'b1010; b = 4'b0110; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(posedge clk); #1;
         if (s_valid && bit_idx == 3'd1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL abort_bit1 got none want bit_idx 1"); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({s, c, s_valid, bit_idx, busy, done} !== 8'd0)
         begin errors++; $display("FAIL abort_outputs got %b want 00000000", {s, c, s_valid, bit_idx, busy, done}); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL abort_release got busy=%b done=%b want 0 0", busy, done); end
      run_op(4'b0010, 4'b0001, 1'b0, 1'b0, bits, oc, nv, nd, iok, bok, to);
      checks++; if (bits !== 4'b0011) begin errors++; $display("FAIL abort_next_bits got %b want 0011", bits); end
      checks++; if (oc !== 1'b0) begin errors++; $display("FAIL abort_next_carry got %b want 0", oc); end
      checks++; if (nd != 1) begin errors++; $display("FAIL abort_next_done got %0d want 1", nd); end
   endtask

   task automatic test_sweep();
      logic [3:0] bits; logic oc; int nv; int nd; bit iok; bit bok; bit to;
      logic [4:0] exp_sum;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               run_op(4'(ia), 4'(ib), 1'(ic), 1'b0, bits, oc, nv, nd, iok, bok, to);
               exp_sum = 5'(ia) + 5'(ib) + 5'(ic);
               checks++;
               if ({oc, bits} !== exp_sum || nv != 4 || nd != 1 || to) begin
                  errors++;
                  $display("FAIL sweep a=%0d b=%0d cin=%0d got sum=%0d valid=%0d done=%0d want sum=%0d valid=4 done=1",
                           ia, ib, ic, {oc, bits}, nv, nd, exp_sum);
               end
            end
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      test_reset();
      test_vectors();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
